// File: rtl/sd_sector_server.sv
// SDRAM-backed responder serving 512-byte SD sector reads/writes from a disk image window.
// Optional macro SD_SERVER_WRPROT_EN makes the image read-only: writes are drained and discarded.
module sd_sector_server #(
    parameter logic [24:0] IMG_BASE    = 25'h0A0000,
    parameter logic [31:0] IMG_SECTORS = 32'd2048,
    parameter int          STROBE_GAP  = 4
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        img_valid,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [7:0]  sd_dout,
    output logic        sd_dout_strobe,
    input  logic [7:0]  sd_din,
    output logic        sd_din_strobe,
    output logic        sd_mounted,
    output logic        oob,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din,
    input  logic        mem_ready
);

`ifdef SD_SERVER_WRPROT_EN
    localparam logic WRPROT = 1'b1;
`else
    localparam logic WRPROT = 1'b0;
`endif

    localparam logic [7:0] GAP_LAST = 8'(STROBE_GAP - 1);
    localparam logic [8:0] CNT_LAST = 9'd511;

    typedef enum logic [2:0] {
        IDLE, ACK, RD_FETCH, RD_BYTE, WR_STROBE, WR_STORE, DONE, REL
    } state_t;

    state_t      state_r;
    logic [15:0] lba_r;
    logic        is_rd_r;
    logic        discard_r;
    logic [8:0]  cnt_r;
    logic [7:0]  gap_r;
    logic [15:0] word_r;
    logic        oob_hit_s;
    logic        wr_block_s;
    logic [8:0]  cnt_inc_s;

    function automatic logic [24:0] word_addr(input logic [15:0] lba, input logic [7:0] widx);
        return IMG_BASE + {lba, 9'd0} + {16'd0, widx, 1'b0};
    endfunction

    // Request classification and counter increment used by the FSM.
    always_comb begin
        oob_hit_s  = (sd_lba >= IMG_SECTORS);
        wr_block_s = WRPROT && !sd_rd;
        cnt_inc_s  = cnt_r + 9'd1;
    end

    // Transfer FSM; every output is a register driven from here.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            lba_r          <= 16'd0;
            is_rd_r        <= 1'b0;
            discard_r      <= 1'b0;
            cnt_r          <= 9'd0;
            gap_r          <= 8'd0;
            word_r         <= 16'd0;
            sd_ack         <= 1'b0;
            sd_dout        <= 8'd0;
            sd_dout_strobe <= 1'b0;
            sd_din_strobe  <= 1'b0;
            sd_mounted     <= 1'b0;
            oob            <= 1'b0;
            mem_addr       <= 25'd0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_dout       <= 16'd0;
        end else begin
            sd_dout_strobe <= 1'b0;
            sd_din_strobe  <= 1'b0;
            oob            <= 1'b0;
            case (state_r)
                IDLE: begin
                    sd_mounted <= img_valid;
                    if (sd_mounted && (sd_rd || sd_wr)) begin
                        lba_r     <= sd_lba[15:0];
                        is_rd_r   <= sd_rd;
                        discard_r <= oob_hit_s || wr_block_s;
                        oob       <= oob_hit_s && !wr_block_s;
                        state_r   <= ACK;
                    end
                end
                ACK: begin
                    sd_ack <= 1'b1;
                    cnt_r  <= 9'd0;
                    gap_r  <= 8'd0;
                    if (!is_rd_r) begin
                        sd_din_strobe <= 1'b1;
                        state_r       <= WR_STROBE;
                    end else if (discard_r) begin
                        word_r         <= 16'd0;
                        sd_dout        <= 8'd0;
                        sd_dout_strobe <= 1'b1;
                        state_r        <= RD_BYTE;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= word_addr(lba_r, 8'd0);
                        state_r  <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    if (mem_ready) begin
                        mem_rd         <= 1'b0;
                        word_r         <= mem_din;
                        sd_dout        <= mem_din[7:0];
                        sd_dout_strobe <= 1'b1;
                        gap_r          <= 8'd0;
                        state_r        <= RD_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (gap_r != GAP_LAST) begin
                        gap_r <= gap_r + 8'd1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                        gap_r <= 8'd0;
                        // Out-of-range reads hold word_r at zero, so the odd byte is zero too.
                        if (!cnt_r[0]) begin
                            sd_dout        <= word_r[15:8];
                            sd_dout_strobe <= 1'b1;
                        end else if (discard_r) begin
                            sd_dout        <= 8'd0;
                            sd_dout_strobe <= 1'b1;
                        end else begin
                            mem_rd   <= 1'b1;
                            mem_addr <= word_addr(lba_r, cnt_inc_s[8:1]);
                            state_r  <= RD_FETCH;
                        end
                    end
                end
                WR_STROBE: begin
                    if (gap_r != GAP_LAST) begin
                        gap_r <= gap_r + 8'd1;
                    end else begin
                        if (cnt_r[0]) begin
                            mem_dout[15:8] <= sd_din;
                        end else begin
                            mem_dout[7:0] <= sd_din;
                        end
                        if (!cnt_r[0]) begin
                            cnt_r         <= cnt_inc_s;
                            gap_r         <= 8'd0;
                            sd_din_strobe <= 1'b1;
                        end else if (!discard_r) begin
                            mem_wr   <= 1'b1;
                            mem_addr <= word_addr(lba_r, cnt_r[8:1]);
                            state_r  <= WR_STORE;
                        end else if (cnt_r == CNT_LAST) begin
                            state_r <= DONE;
                        end else begin
                            cnt_r         <= cnt_inc_s;
                            gap_r         <= 8'd0;
                            sd_din_strobe <= 1'b1;
                        end
                    end
                end
                WR_STORE: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= DONE;
                        end else begin
                            cnt_r         <= cnt_inc_s;
                            gap_r         <= 8'd0;
                            sd_din_strobe <= 1'b1;
                            state_r       <= WR_STROBE;
                        end
                    end
                end
                DONE: begin
                    sd_ack  <= 1'b0;
                    state_r <= REL;
                end
                REL: begin
                    sd_mounted <= img_valid;
                    if (!sd_rd && !sd_wr) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
